// File: rtl/imem_loader_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CKSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [29:0] DEF_BASE_WORD = 30'h00100000;
  localparam int          DEF_MAX_WORDS = 1024;
  localparam int          HDR_LEN       = 2;

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Big-endian byte-to-word assembler: keeps the three leading bytes and a
// byte index, and presents the full word alongside the fourth byte.
module byte_to_word
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_complete
);

  logic [23:0] r_word;
  logic [1:0]  r_idx;

  // Only three bytes are stored; the fourth is combined on the fly so the
  // word is ready at the same edge that accepts its last byte.
  assign o_word          = {r_word, i_byte};
  assign o_word_complete = i_shift_en && (r_idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_idx  <= '0;
    end else if (i_shift_en) begin
      r_word <= {r_word[15:0], i_byte};
      r_idx  <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: writes big-endian words to the
// instruction memory and holds the core until the checksum verifies.
module imem_loader
  import loader_pkg::*;
#(
  parameter int                ADDR_W    = 30,
  parameter logic [ADDR_W-1:0] BASE_WORD = ADDR_W'(DEF_BASE_WORD),
  parameter int                MAX_WORDS = DEF_MAX_WORDS
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_word_cnt;
  logic [7:0]        r_cksum;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_error;

  logic              w_hs;
  logic              w_start_ok;
  logic [15:0]       w_len_next;
  logic [31:0]       w_word;
  logic              w_word_complete;

  assign in_ready   = r_state inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CKSUM};
  assign w_hs       = in_valid && in_ready;
  assign w_start_ok = start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
  assign w_len_next = {r_len[15:8], in_data};

  byte_to_word u_b2w (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_clr           (w_start_ok),
    .i_shift_en      (w_hs && (r_state == ST_DATA)),
    .i_byte          (in_data),
    .o_word          (w_word),
    .o_word_complete (w_word_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_cksum      <= '0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_cpu_hold   <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            r_state    <= ST_LEN_HI;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cksum    <= '0;
            r_word_cnt <= '0;
          end
        end
        ST_LEN_HI: begin
          if (w_hs) begin
            r_len[15:8] <= in_data;
            r_cksum     <= r_cksum + in_data;
            r_state     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_hs) begin
            r_len   <= w_len_next;
            r_cksum <= r_cksum + in_data;
            if (w_len_next > MAX_N) begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end else if (w_len_next == 16'd0) begin
              r_state <= ST_CKSUM;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            r_cksum <= r_cksum + in_data;
            if (w_word_complete) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= BASE_WORD + ADDR_W'(r_word_cnt);
              r_imem_wdata <= w_word;
              r_word_cnt   <= r_word_cnt + 16'd1;
              if (r_word_cnt == r_len - 16'd1) begin
                r_state <= ST_CKSUM;
              end
            end
          end
        end
        ST_CKSUM: begin
          if (w_hs) begin
            if (in_data == r_cksum) begin
              r_state    <= ST_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: framing, checksum, limits,
// flow-control gaps and asynchronous reset during a load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [29:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  int          wr_total = 0;
  logic [29:0] wr_addr [64];
  logic [31:0] wr_data [64];

  logic [7:0] good_frame [11] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                                  8'h01, 8'h09, 8'h50, 8'h20, 8'hA9};

  imem_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Write log, sampled on the falling edge away from register updates.
  always @(negedge clk) begin
    if (imem_we && wr_total < 64) begin
      wr_addr[wr_total] = imem_addr;
      wr_data[wr_total] = imem_wdata;
      wr_total++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bench-driven activity happens 1 time unit after a rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    if (in_ready) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic check_good_writes(input string tag, input int base);
    check({tag, "_nwr"},   wr_total - base, 32'd2);
    check({tag, "_addr0"}, {2'b0, wr_addr[base]},     32'h0010_0000);
    check({tag, "_data0"}, wr_data[base],             32'h2008_0005);
    check({tag, "_addr1"}, {2'b0, wr_addr[base + 1]}, 32'h0010_0001);
    check({tag, "_data1"}, wr_data[base + 1],         32'h0109_5020);
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic h);
    check({tag, "_done"},  {31'd0, done},     {31'd0, d});
    check({tag, "_error"}, {31'd0, error},    {31'd0, e});
    check({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, h});
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    int base;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, imem_we},  32'd0);
    check("rst_addr",  {2'b0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata,        32'd0);
    check_flags("rst", 1'b0, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Good 2-word frame, with write-latency checks at word boundaries
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      send_byte(good_frame[i], 0);
      if (i == 4) check("good_no_we_mid", {31'd0, imem_we}, 32'd0);
      if (i == 5) begin
        check("good_we0_lat",  {31'd0, imem_we}, 32'd1);
        check("good_addr0_lat", {2'b0, imem_addr}, 32'h0010_0000);
      end
      if (i == 9) begin
        check("good_we1_lat",  {31'd0, imem_we}, 32'd1);
        check("good_data1_lat", imem_wdata, 32'h0109_5020);
      end
    end
    check_good_writes("good", base);
    check_flags("good", 1'b1, 1'b0, 1'b0);

    // Bad checksum: writes still occur, then error
    base = wr_total;
    pulse_start();
    check("restart_clears_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 10; i++) send_byte(good_frame[i], 0);
    send_byte(8'hA8, 0);
    check_good_writes("bad", base);
    check_flags("bad", 1'b0, 1'b1, 1'b1);

    // Empty image with a correct checksum (sum of 00 00 is 00)
    base = wr_total;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("empty_nwr", wr_total - base, 32'd0);
    check_flags("empty", 1'b1, 1'b0, 1'b0);

    // Empty image whose checksum byte is wrong
    base = wr_total;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    check("empty_bad_nwr", wr_total - base, 32'd0);
    check_flags("empty_bad", 1'b0, 1'b1, 1'b1);

    // Oversize count N=1025
    base = wr_total;
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("over_nwr", wr_total - base, 32'd0);
    check_flags("over", 1'b0, 1'b1, 1'b1);

    // Boundary N=1024 is accepted into the data phase
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    check("max_ready", {31'd0, in_ready}, 32'd1);
    check("max_error", {31'd0, error}, 32'd0);

    // Reset mid-load after the 6th byte (that byte completes word 0)
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(good_frame[i], 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_we", {31'd0, imem_we}, 32'd0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    check("mid_rst_nwr", wr_total - base, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 11; i++) send_byte(good_frame[i], 0);
    check_good_writes("after_rst", base);
    check_flags("after_rst", 1'b1, 1'b0, 1'b0);

    // Flow-control gaps, plus a stray start during the data phase
    base = wr_total;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      send_byte(good_frame[i], $urandom_range(0, 5));
      if (i == 4) pulse_start();
    end
    repeat (2) begin @(posedge clk); #1; end
    check_good_writes("gaps", base);
    check_flags("gaps", 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
